add16_rc_cla: RTL and testbench

Registered 16-bit dual-architecture adder. A 16-stage ripple-carry adder and a two-level carry-lookahead adder both compute `a16 + b16 + cin` from the same operands, and each result is registered. A registered cross-check flag reports any disagreement between the two. The block is the lab datapath's arithmetic unit and serves as a side-by-side reference for comparing the two adder architectures.

---
 rtl/add16_rc_cla.sv | 107 ++++++++++
 tb/tb_add16_rc_cla.sv | 126 ++++++++++++
 2 files changed

// File: rtl/add16_rc_cla.sv
// Registered 16-bit adder built twice: a ripple-carry core and a two-level CLA core.
// The two results are compared every cycle; any disagreement is flagged on mismatch.
module add16_rc_cla (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a16,
  input  logic [15:0] b16,
  input  logic        cin,
  output logic [15:0] sum16_rc,
  output logic        cout_rc,
  output logic [15:0] sum16_cla,
  output logic        cout_cla,
  output logic        mismatch
);

  logic [16:0] w_c_rc;
  logic [15:0] w_s_rc;

  assign w_c_rc[0] = cin;

  for (genvar i = 0; i < 16; i++) begin : g_rc
    assign w_s_rc[i]   = a16[i] ^ b16[i] ^ w_c_rc[i];
    assign w_c_rc[i+1] = (a16[i] & b16[i]) | (w_c_rc[i] & (a16[i] ^ b16[i]));
  end

  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_c_cla;
  logic [3:0]  w_grp_g;
  logic [3:0]  w_grp_p;
  logic [4:0]  w_grp_c;
  logic [15:0] w_s_cla;

  assign w_g = a16 & b16;
  assign w_p = a16 ^ b16;

  for (genvar k = 0; k < 4; k++) begin : g_cla_grp
    localparam int B = 4 * k;

    assign w_grp_g[k] = w_g[B+3]
                      | (w_p[B+3] & w_g[B+2])
                      | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                      | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
    assign w_grp_p[k] = w_p[B+3] & w_p[B+2] & w_p[B+1] & w_p[B];

    // In-group carries start from the group carry supplied by the second level.
    assign w_c_cla[B]   = w_grp_c[k];
    assign w_c_cla[B+1] = w_g[B] | (w_p[B] & w_grp_c[k]);
    assign w_c_cla[B+2] = w_g[B+1]
                        | (w_p[B+1] & w_g[B])
                        | (w_p[B+1] & w_p[B] & w_grp_c[k]);
    assign w_c_cla[B+3] = w_g[B+2]
                        | (w_p[B+2] & w_g[B+1])
                        | (w_p[B+2] & w_p[B+1] & w_g[B])
                        | (w_p[B+2] & w_p[B+1] & w_p[B] & w_grp_c[k]);
  end

  // Second-level lookahead: every group carry is a flat function of G, P and cin.
  assign w_grp_c[0] = cin;
  assign w_grp_c[1] = w_grp_g[0] | (w_grp_p[0] & cin);
  assign w_grp_c[2] = w_grp_g[1]
                    | (w_grp_p[1] & w_grp_g[0])
                    | (w_grp_p[1] & w_grp_p[0] & cin);
  assign w_grp_c[3] = w_grp_g[2]
                    | (w_grp_p[2] & w_grp_g[1])
                    | (w_grp_p[2] & w_grp_p[1] & w_grp_g[0])
                    | (w_grp_p[2] & w_grp_p[1] & w_grp_p[0] & cin);
  assign w_grp_c[4] = w_grp_g[3]
                    | (w_grp_p[3] & w_grp_g[2])
                    | (w_grp_p[3] & w_grp_p[2] & w_grp_g[1])
                    | (w_grp_p[3] & w_grp_p[2] & w_grp_p[1] & w_grp_g[0])
                    | (w_grp_p[3] & w_grp_p[2] & w_grp_p[1] & w_grp_p[0] & cin);

  assign w_s_cla = w_p ^ w_c_cla;

  logic w_diff;
  assign w_diff = {w_c_rc[16], w_s_rc} != {w_grp_c[4], w_s_cla};

  logic [15:0] r_sum_rc;
  logic        r_cout_rc;
  logic [15:0] r_sum_cla;
  logic        r_cout_cla;
  logic        r_mismatch;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum_rc   <= '0;
      r_cout_rc  <= 1'b0;
      r_sum_cla  <= '0;
      r_cout_cla <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      r_sum_rc   <= w_s_rc;
      r_cout_rc  <= w_c_rc[16];
      r_sum_cla  <= w_s_cla;
      r_cout_cla <= w_grp_c[4];
      r_mismatch <= w_diff;
    end
  end

  assign sum16_rc  = r_sum_rc;
  assign cout_rc   = r_cout_rc;
  assign sum16_cla = r_sum_cla;
  assign cout_cla  = r_cout_cla;
  assign mismatch  = r_mismatch;

endmodule

// File: tb/tb_add16_rc_cla.sv
// Bench for add16_rc_cla: directed vector table, reset sequences and a random
// regression against a plain 17-bit arithmetic reference.
module tb_add16_rc_cla;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        cin;
  logic [15:0] sum16_rc;
  logic        cout_rc;
  logic [15:0] sum16_cla;
  logic        cout_cla;
  logic        mismatch;

  int n_checks = 0;
  int n_fail   = 0;

  add16_rc_cla dut (
    .clk       (clk),
    .rst       (rst),
    .a16       (a16),
    .b16       (b16),
    .cin       (cin),
    .sum16_rc  (sum16_rc),
    .cout_rc   (cout_rc),
    .sum16_cla (sum16_cla),
    .cout_cla  (cout_cla),
    .mismatch  (mismatch)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [15:0] es, input logic ec);
    chk({name, " sum_rc"},   {16'h0, sum16_rc},  {16'h0, es});
    chk({name, " cout_rc"},  {31'h0, cout_rc},   {31'h0, ec});
    chk({name, " sum_cla"},  {16'h0, sum16_cla}, {16'h0, es});
    chk({name, " cout_cla"}, {31'h0, cout_cla},  {31'h0, ec});
    chk({name, " mismatch"}, {31'h0, mismatch},  32'h0);
  endtask

  task automatic drive(input logic r, input logic [15:0] a, input logic [15:0] b, input logic ci);
    rst = r;
    a16 = a;
    b16 = b;
    cin = ci;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [16:0] ref_sum;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;

    vecs[0] = '{"bnd 0000+FFFE+1", 16'h0000, 16'hFFFE, 1'b1, 16'hFFFF, 1'b0};
    vecs[1] = '{"bnd 0000+FFFF+0", 16'h0000, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0};
    vecs[2] = '{"bnd 7FFF+0001+0", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
    vecs[3] = '{"chain 5555+AAAA+1", 16'h5555, 16'hAAAA, 1'b1, 16'h0000, 1'b1};
    vecs[4] = '{"mix 8492+7A9E+0", 16'h8492, 16'h7A9E, 1'b0, 16'hFF30, 1'b0};
    vecs[5] = '{"mix 7EBC+D976+1", 16'h7EBC, 16'hD976, 1'b1, 16'h5833, 1'b1};

    // Reset held with all-ones operands; outputs must stay zero.
    drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    step();
    chk_all("reset cyc1", 16'h0000, 1'b0);
    step();
    chk_all("reset cyc2", 16'h0000, 1'b0);
    rst = 1'b0;
    step();
    chk_all("post reset FFFF+FFFF+1", 16'hFFFF, 1'b1);

    // Back-to-back table vectors; each result one edge after its operands.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, vecs[i].a, vecs[i].b, vecs[i].ci);
      step();
      chk_all(vecs[i].name, vecs[i].exp_sum, vecs[i].exp_cout);
    end

    // Reset pulse mid-stream: operands on the reset edge are dropped.
    drive(1'b1, 16'h1234, 16'h4321, 1'b1);
    step();
    chk_all("midstream reset", 16'h0000, 1'b0);
    drive(1'b0, 16'h1234, 16'h4321, 1'b1);
    step();
    chk_all("after midstream reset", 16'h5556, 1'b0);

    // Random regression against 17-bit arithmetic.
    for (int i = 0; i < 10000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      ref_sum = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
      drive(1'b0, ra, rb, rc);
      step();
      chk_all("random", ref_sum[15:0], ref_sum[16]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
